// File: rtl/branch_redirect_ctrl.sv
// Buffers resolved branches by ROB tag, grants in-order commit, and recovers from taken (mispredicted) branches; BRANCH_REDIRECT_STATS_EN adds commit/mispredict counters.
// br_commit is combinational; flush follows a taken commit by one cycle and redirect by two, with redirect held until redirect_ready.
module branch_redirect_ctrl #(
    parameter int TAG_W = 5,
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_taken,
    input  logic [XLEN-1:0]  res_pc,
    input  logic             head_valid,
    input  logic [TAG_W-1:0] head_tag,
    output logic             br_commit,
    output logic             flush,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    input  logic             redirect_ready,
    output logic             overflow
`ifdef BRANCH_REDIRECT_STATS_EN
    ,
    output logic [31:0]      stat_resolved,
    output logic [31:0]      stat_mispredict
`endif
);

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic             taken;
        logic [XLEN-1:0]  pc;
    } entry_t;

    localparam logic [TAG_W-1:0] TAG_NONE = '1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_REDIR = 2'd2;

    entry_t          ent_q [DEPTH];
    logic [1:0]      state_q;

    logic [DEPTH-1:0] hit_vec;
    logic [DEPTH-1:0] res_vec;
    logic [DEPTH-1:0] free_vec;
    logic [DEPTH-1:0] wr_sel;
    logic             hit_taken;
    logic [XLEN-1:0]  hit_pc;
    logic             res_ins;
    logic             drop;
    logic             free_found;

    always_comb begin
        hit_vec    = '0;
        res_vec    = '0;
        hit_taken  = 1'b0;
        hit_pc     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i] = ent_q[i].vld && (ent_q[i].tag == head_tag) && (head_tag != TAG_NONE);
            res_vec[i] = ent_q[i].vld && (ent_q[i].tag == res_tag);
            if (hit_vec[i]) begin
                hit_taken = ent_q[i].taken;
                hit_pc    = ent_q[i].pc;
            end
        end
        br_commit = !rst && (state_q == S_IDLE) && head_valid && (|hit_vec);
        res_ins   = (state_q == S_IDLE) && (res_tag != TAG_NONE);

        // A slot being retired this cycle can take the incoming result.
        free_found = 1'b0;
        wr_sel     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_vec[i] = !ent_q[i].vld || (br_commit && hit_vec[i]);
            if (free_vec[i] && !free_found) begin
                wr_sel[i]  = 1'b1;
                free_found = 1'b1;
            end
        end
        if (|res_vec) begin
            wr_sel = res_vec;
        end
        drop = res_ins && !(|res_vec) && !free_found;
    end

    assign flush          = (state_q == S_FLUSH);
    assign redirect_valid = (state_q == S_REDIR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            state_q     <= S_IDLE;
            redirect_pc <= '0;
            overflow    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (br_commit && hit_vec[i]) begin
                            ent_q[i].vld <= 1'b0;
                        end
                        if (res_ins && wr_sel[i]) begin
                            ent_q[i] <= '{vld: 1'b1, tag: res_tag, taken: res_taken, pc: res_pc};
                        end
                    end
                    if (drop) begin
                        overflow <= 1'b1;
                    end
                    if (br_commit && hit_taken) begin
                        redirect_pc <= hit_pc;
                        state_q     <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        ent_q[i].vld <= 1'b0;
                    end
                    state_q <= S_REDIR;
                end
                S_REDIR: begin
                    if (redirect_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef BRANCH_REDIRECT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else begin
            if (br_commit) begin
                stat_resolved <= stat_resolved + 32'd1;
            end
            if (br_commit && hit_taken) begin
                stat_mispredict <= stat_mispredict + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench: stimulus pushes per-cycle expectations from a tag-keyed model; a negedge monitor compares.
module tb_branch_redirect_ctrl;

    localparam int DEPTH = 4;
    localparam logic [4:0] ALL1 = 5'h1f;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  res_tag = ALL1;
    logic        res_taken = 1'b0;
    logic [31:0] res_pc = '0;
    logic        head_valid = 1'b0;
    logic [4:0]  head_tag = '0;
    logic        redirect_ready = 1'b0;
    logic        br_commit, flush, redirect_valid, overflow;
    logic [31:0] redirect_pc;
`ifdef BRANCH_REDIRECT_STATS_EN
    logic [31:0] stat_resolved, stat_mispredict;
`endif

    branch_redirect_ctrl #(.TAG_W(5), .XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .res_tag(res_tag), .res_taken(res_taken), .res_pc(res_pc),
        .head_valid(head_valid), .head_tag(head_tag), .br_commit(br_commit), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .overflow(overflow)
`ifdef BRANCH_REDIRECT_STATS_EN
        , .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  tag;
        bit          taken;
        logic [31:0] pc;
    } br_t;

    typedef struct {
        bit          commit;
        bit          flush;
        bit          rv;
        bit          ovf;
        logic [31:0] pc;
        logic [31:0] s_res;
        logic [31:0] s_mis;
    } exp_t;

    br_t         pend[$];
    exp_t        exp_q[$];
    int          m_phase;   // 0 normal, 1 squash cycle due, 2 waiting for fetch to take the redirect
    logic [31:0] m_pc;
    bit          m_ovf;
    logic [31:0] m_sres, m_smis;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int find(input logic [4:0] t);
        foreach (pend[i]) if (pend[i].tag == t) return i;
        return -1;
    endfunction

    task automatic model_clear();
        pend.delete();
        m_phase = 0;
        m_pc    = '0;
        m_ovf   = 1'b0;
        m_sres  = '0;
        m_smis  = '0;
    endtask

    task automatic step(input logic [4:0] rt, input bit rtk, input logic [31:0] rpc,
                        input bit hv, input logic [4:0] ht, input bit rdy);
        exp_t e;
        int   k;
        @(posedge clk);
        #1;
        res_tag = rt; res_taken = rtk; res_pc = rpc;
        head_valid = hv; head_tag = ht; redirect_ready = rdy;
        e = '{commit: 0, flush: 0, rv: 0, ovf: m_ovf, pc: m_pc, s_res: m_sres, s_mis: m_smis};
        if (m_phase == 1) begin
            e.flush = 1;
            pend.delete();
            m_phase = 2;
        end else if (m_phase == 2) begin
            e.rv = 1;
            if (rdy) m_phase = 0;
        end else begin
            k = find(ht);
            if (hv && k >= 0) begin
                e.commit = 1;
                m_sres++;
                if (pend[k].taken) begin
                    m_pc    = pend[k].pc;
                    m_phase = 1;
                    m_smis++;
                end
                pend.delete(k);
            end
            if (rt != ALL1) begin
                k = find(rt);
                if (k >= 0) begin
                    pend[k].taken = rtk;
                    pend[k].pc    = rpc;
                end else if (pend.size() < DEPTH) begin
                    pend.push_back('{tag: rt, taken: rtk, pc: rpc});
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(ALL1, 0, 0, 0, 0, 1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_br_commit", {31'd0, br_commit}, 0);
        chk("rst_flush", {31'd0, flush}, 0);
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
`ifdef BRANCH_REDIRECT_STATS_EN
        chk("rst_stat_resolved", stat_resolved, 0);
        chk("rst_stat_mispredict", stat_mispredict, 0);
`endif
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        head_valid = 1; head_tag = 0; res_tag = ALL1; redirect_ready = 0;
        rst = 1;
        #1;
        check_reset_outputs();
        model_clear();
        head_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("br_commit", {31'd0, br_commit}, {31'd0, e.commit});
            chk("flush", {31'd0, flush}, {31'd0, e.flush});
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
            chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
            if (e.rv) chk("redirect_pc", redirect_pc, e.pc);
`ifdef BRANCH_REDIRECT_STATS_EN
            chk("stat_resolved", stat_resolved, e.s_res);
            chk("stat_mispredict", stat_mispredict, e.s_mis);
`endif
        end
    end

    initial begin
        model_clear();
        head_valid = 1;
        #2;
        check_reset_outputs();
        head_valid = 0;
        @(posedge clk);
        #1;
        rst = 0;

        // not-taken commit, slot freed
        step(3, 0, 0, 0, 0, 0);
        step(ALL1, 0, 0, 1, 3, 0);
        step(ALL1, 0, 0, 1, 3, 0);
        // taken commit with redirect back-pressured three cycles
        step(5, 1, 32'h40, 0, 0, 0);
        step(ALL1, 0, 0, 1, 5, 0);
        step(ALL1, 0, 0, 0, 0, 0);
        step(ALL1, 0, 0, 0, 0, 0);
        step(ALL1, 0, 0, 0, 0, 0);
        step(ALL1, 0, 0, 0, 0, 0);
        step(ALL1, 0, 0, 0, 0, 1);
        idle(1);
        // fill, overflow, reuse of a slot freed by the same-cycle commit
        step(1, 0, 32'h10, 0, 0, 0);
        step(2, 0, 32'h20, 0, 0, 0);
        step(3, 0, 32'h30, 0, 0, 0);
        step(4, 0, 32'h44, 0, 0, 0);
        step(6, 0, 32'h60, 0, 0, 0);
        step(7, 0, 32'h70, 1, 1, 0);
        step(ALL1, 0, 0, 1, 7, 0);
        step(ALL1, 0, 0, 1, 2, 0);
        step(ALL1, 0, 0, 1, 3, 0);
        step(ALL1, 0, 0, 1, 4, 0);
        // overwrite of an already-resolved tag
        step(2, 0, 32'h0, 0, 0, 0);
        step(2, 1, 32'h100, 0, 0, 0);
        step(ALL1, 0, 0, 1, 2, 1);
        step(ALL1, 0, 0, 1, 2, 1);
        step(ALL1, 0, 0, 1, 2, 1);
        step(ALL1, 0, 0, 1, 2, 1);
        // wrong-path results during recovery are discarded
        step(8, 1, 32'h80, 0, 0, 0);
        step(ALL1, 0, 0, 1, 8, 0);
        step(9, 0, 32'h90, 0, 0, 0);
        step(9, 0, 32'h90, 0, 0, 0);
        step(9, 0, 32'h90, 0, 0, 1);
        step(ALL1, 0, 0, 1, 9, 1);
        step(ALL1, 0, 0, 1, 9, 1);
        // reset while redirect is pending
        step(5, 1, 32'hdead_0000, 0, 0, 0);
        step(ALL1, 0, 0, 1, 5, 0);
        step(ALL1, 0, 0, 0, 0, 0);
        step(ALL1, 0, 0, 0, 0, 0);
        do_reset();
        step(ALL1, 0, 0, 1, 5, 1);
        step(ALL1, 0, 0, 1, 5, 1);

        for (int n = 0; n < 600; n++) begin
            logic [4:0] rt, ht;
            bit hv;
            if (n % 150 == 149) do_reset();
            rt = ($urandom_range(0, 3) == 0) ? ALL1 : 5'($urandom_range(0, 9));
            hv = $urandom_range(0, 1) == 1;
            if (pend.size() > 0 && $urandom_range(0, 2) != 0)
                ht = pend[$urandom_range(0, pend.size() - 1)].tag;
            else
                ht = 5'($urandom_range(0, 31));
            step(rt, $urandom_range(0, 4) == 0, $urandom, hv, ht, $urandom_range(0, 2) != 0);
        end

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences branch outcomes produced by the branch unit into in-order control-flow recovery.
- Buffers resolved branches keyed by ROB tag until the branch reaches the ROB head.
- On commit, grants the ROB commit of that branch.
- If the branch is taken, it mispredicted (static not-taken prediction). The block then drives a one-cycle pipeline flush and holds a PC redirect to fetch until fetch accepts it.

Parameters:
- TAG_W, 5, ROB tag width; tag value all-ones = invalid (no result).
- XLEN, 32, PC width.
- DEPTH, 4, resolved-branch buffer entries (2..8).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- res_tag  input  TAG_W  tag of branch resolved by branch unit this cycle; all-ones = none.
- res_taken  input  1  comparison result (1 = taken).
- res_pc  input  XLEN  taken target (pc + offset).
- head_valid  input  1  ROB head is a branch awaiting commit.
- head_tag  input  TAG_W  tag of ROB head.
- br_commit  output  1  combinational; head branch is resolved and may retire this cycle.
- flush  output  1  registered one-cycle squash of all speculative state.
- redirect_valid  output  1  fetch redirect request.
- redirect_pc  output  XLEN  redirect target; stable while redirect_valid.
- redirect_ready  input  1  fetch accepts redirect.
- overflow  output  1  sticky error: result dropped because the buffer was full.

Behaviour:
- Reset values (asynchronous): all buffer entries invalid, state IDLE, flush=0, redirect_valid=0, redirect_pc=0, overflow=0. br_commit=0 while rst is high. Reset mid-flush or mid-redirect abandons the operation immediately.
- Buffer entry fields: {valid, tag, taken, pc}.
- Insert rule, IDLE only: when res_tag != all-ones:
  - If a valid entry has an equal tag, overwrite it.
  - Otherwise write the lowest-index invalid entry. A slot freed by br_commit in the same cycle counts as free.
  - If no slot is free, drop the result and set overflow (cleared only by rst).
- An inserted result is visible to the head lookup from the next cycle. There is no same-cycle bypass.
- FSM states IDLE, FLUSH, REDIRECT:
  - IDLE: br_commit = head_valid & (some valid entry tag == head_tag).
    - On br_commit, the matching entry is invalidated at the clock edge.
    - If its taken=1: latch redirect_pc <= entry.pc and go to FLUSH.
    - Otherwise stay in IDLE.
  - FLUSH: flush=1 for exactly this one cycle. All entries are invalidated at the edge. res inputs are ignored. br_commit=0. Next state is REDIRECT.
  - REDIRECT: redirect_valid=1, redirect_pc held. res inputs are ignored (stale wrong-path results). br_commit=0. When redirect_ready=1, go to IDLE; redirect_valid is 0 the following cycle.
- Redirect latency: from the br_commit cycle of a taken branch, flush is asserted the next cycle and redirect_valid the cycle after. The minimum mispredict recovery is 3 cycles with redirect_ready tied high.
- At most one br_commit per cycle. Multiple matching entries cannot exist because of the overwrite rule.
- Tag compare is exact over TAG_W bits. head_tag all-ones never matches.

Optional Feature:
- Macro: BRANCH_REDIRECT_STATS_EN.
- When defined, the block adds two outputs:
  - stat_resolved [31:0]: increments on every br_commit.
  - stat_mispredict [31:0]: increments on every IDLE->FLUSH transition.
  - Both counters reset to 0 on rst and wrap modulo 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
1. res_tag=3, taken=0; next cycle head_valid=1, head_tag=3 -> br_commit=1 that cycle, no flush, entry freed, state stays IDLE.
2. res_tag=5, taken=1, res_pc=0x0000_0040; head_tag=5 -> br_commit=1 at cycle N. flush=1 only at N+1, all entries cleared. redirect_valid=1 with redirect_pc=0x40 from N+2. With redirect_ready held 0 for 3 cycles and then 1, redirect_valid stays high 4 cycles, then drops.
3. DEPTH=4: insert tags 1,2,3,4 with no commit, then tag 6 -> overflow=1 and stays 1. Then head_tag=1 commits while tag 7 arrives in the same cycle -> tag 7 is stored (freed slot reused); a later head_tag=7 commits.
4. Insert tag 2 taken=0, then tag 2 again taken=1, pc=0x100; head_tag=2 -> single commit, FSM goes to FLUSH, redirect_pc=0x100.
5. res_tag=9 presented during FLUSH and during REDIRECT -> not stored; head_tag=9 after return to IDLE gives br_commit=0.
6. Assert rst while in REDIRECT with redirect_valid=1 -> redirect_valid, flush and overflow go to 0 immediately (before any clock edge), buffer is empty after reset, FSM restarts in IDLE. With BRANCH_REDIRECT_STATS_EN defined, both stat counters read 0.
